// File: rtl/match_job_scheduler_pkg.sv
// Shared types and default sizing for the pattern-match job scheduler.
package match_sched_pkg;
   localparam int DEF_DEPTH   = 4;
   localparam int DEF_PID_W   = 4;
   localparam int DEF_TIMEOUT = 64;
   localparam int DEF_CNT_W   = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LAUNCH = 3'd1,
      WAIT   = 3'd2,
      ABORT  = 3'd3,
      REPORT = 3'd4
   } state_e;
endpackage

// File: rtl/match_job_scheduler_if.sv
// Host job channel, matcher control channel and result channel of the scheduler.
interface match_sched_if #(parameter int PID_W = 4);
   logic             job_valid;
   logic             job_ready;
   logic [PID_W-1:0] job_pat_id;
   logic             m_ready;
   logic [PID_W-1:0] m_pat_id;
   logic             m_done;
   logic             m_found;
   logic             m_error;
   logic             m_abort;
   logic             res_valid;
   logic             res_ack;
   logic [PID_W-1:0] res_pat_id;
   logic             res_found;
   logic             res_error;
   logic             res_timeout;

   modport slave (
      input  job_valid, job_pat_id, m_done, m_found, m_error, res_ack,
      output job_ready, m_ready, m_pat_id, m_abort,
             res_valid, res_pat_id, res_found, res_error, res_timeout
   );

   modport master (
      output job_valid, job_pat_id, m_done, m_found, m_error, res_ack,
      input  job_ready, m_ready, m_pat_id, m_abort,
             res_valid, res_pat_id, res_found, res_error, res_timeout
   );
endinterface

// File: rtl/match_job_scheduler_fifo.sv
// Synchronous DEPTH x W job FIFO; a push while full or a pop while empty is dropped.
module job_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic                     clock,
   input  logic                     reset_N,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          wr_en, rd_en;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];
   assign wr_en = push && !full;
   assign rd_en = pop && !empty;

   // Pointers are exactly AW bits, so the increment wraps modulo DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_N) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/match_job_scheduler.sv
// Launches queued pattern-match jobs one at a time, watches for done or timeout,
// and reports each result with running hit/error statistics.
module match_job_scheduler
   import match_sched_pkg::*;
#(
   parameter int DEPTH   = DEF_DEPTH,
   parameter int PID_W   = DEF_PID_W,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                     clock,
   input  logic                     reset_N,
   match_sched_if.slave             bus,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [CNT_W-1:0]         hit_count,
   output logic [CNT_W-1:0]         err_count
);
   localparam int TW = $clog2(TIMEOUT);

   state_e           state_q, state_d;
   logic [TW-1:0]    cnt_q, cnt_d;
   logic [PID_W-1:0] m_pat_id_q, m_pat_id_d;
   logic [PID_W-1:0] res_pat_id_q, res_pat_id_d;
   logic             res_found_q, res_found_d;
   logic             res_error_q, res_error_d;
   logic             res_timeout_q, res_timeout_d;
   logic [CNT_W-1:0] hit_q, hit_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             hit_inc, err_inc;
   logic             pop;
   logic             fifo_full, fifo_empty;
   logic [PID_W-1:0] fifo_head;

   job_fifo #(.DEPTH(DEPTH), .W(PID_W)) u_fifo (
      .clock   (clock),
      .reset_N (reset_N),
      .push    (bus.job_valid),
      .din     (bus.job_pat_id),
      .pop     (pop),
      .dout    (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      m_pat_id_d    = m_pat_id_q;
      res_pat_id_d  = res_pat_id_q;
      res_found_d   = res_found_q;
      res_error_d   = res_error_q;
      res_timeout_d = res_timeout_q;
      hit_inc       = 1'b0;
      err_inc       = 1'b0;
      pop           = 1'b0;
      bus.m_ready   = 1'b0;
      bus.m_abort   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d    = LAUNCH;
               m_pat_id_d = fifo_head;
            end
         end
         LAUNCH: begin
            bus.m_ready = 1'b1;
            pop         = 1'b1;
            cnt_d       = '0;
            state_d     = WAIT;
         end
         WAIT: begin
            // A done arriving on the last allowed cycle still counts as a normal finish.
            if (bus.m_done) begin
               res_found_d   = bus.m_found;
               res_error_d   = bus.m_error;
               res_timeout_d = 1'b0;
               res_pat_id_d  = m_pat_id_q;
               hit_inc       = bus.m_found && !bus.m_error;
               err_inc       = bus.m_error;
               state_d       = REPORT;
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
               state_d = ABORT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         ABORT: begin
            bus.m_abort   = 1'b1;
            res_found_d   = 1'b0;
            res_error_d   = 1'b0;
            res_timeout_d = 1'b1;
            res_pat_id_d  = m_pat_id_q;
            err_inc       = 1'b1;
            state_d       = REPORT;
         end
         REPORT: begin
            if (bus.res_ack) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      hit_d = (hit_inc && hit_q != '1) ? hit_q + CNT_W'(1) : hit_q;
      err_d = (err_inc && err_q != '1) ? err_q + CNT_W'(1) : err_q;
   end

   always_ff @(posedge clock) begin
      if (!reset_N) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         m_pat_id_q    <= '0;
         res_pat_id_q  <= '0;
         res_found_q   <= 1'b0;
         res_error_q   <= 1'b0;
         res_timeout_q <= 1'b0;
         hit_q         <= '0;
         err_q         <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         m_pat_id_q    <= m_pat_id_d;
         res_pat_id_q  <= res_pat_id_d;
         res_found_q   <= res_found_d;
         res_error_q   <= res_error_d;
         res_timeout_q <= res_timeout_d;
         hit_q         <= hit_d;
         err_q         <= err_d;
      end
   end

   assign bus.job_ready   = !fifo_full;
   assign bus.m_pat_id    = m_pat_id_q;
   assign bus.res_valid   = (state_q == REPORT);
   assign bus.res_pat_id  = res_pat_id_q;
   assign bus.res_found   = res_found_q;
   assign bus.res_error   = res_error_q;
   assign bus.res_timeout = res_timeout_q;
   assign busy            = (state_q != IDLE) || !fifo_empty;
   assign hit_count       = hit_q;
   assign err_count       = err_q;
endmodule
